// File: rtl/mask_unit_read_rr_xbar.sv
// Read-request crossbar: NUM_IN requesters routed to NUM_LANE lanes, each lane
// with an independent round-robin arbiter feeding a 2-entry output FIFO.
module mask_unit_read_rr_xbar #(
  parameter int NUM_IN   = 4,
  parameter int NUM_LANE = 4,
  parameter int VS_W     = 5,
  parameter int OFFSET_W = 8,
  parameter int DOFF_W   = 2,
  localparam int LANE_W  = (NUM_LANE > 1) ? $clog2(NUM_LANE) : 1,
  localparam int IDX_W   = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_IN-1:0]            in_valid,
  output logic [NUM_IN-1:0]            in_ready,
  input  logic [NUM_IN*VS_W-1:0]       in_vs,
  input  logic [NUM_IN*OFFSET_W-1:0]   in_offset,
  input  logic [NUM_IN*LANE_W-1:0]     in_read_lane,
  input  logic [NUM_IN*DOFF_W-1:0]     in_data_offset,
  output logic [NUM_LANE-1:0]          out_valid,
  input  logic [NUM_LANE-1:0]          out_ready,
  output logic [NUM_LANE*VS_W-1:0]     out_vs,
  output logic [NUM_LANE*OFFSET_W-1:0] out_offset,
  output logic [NUM_LANE*IDX_W-1:0]    out_write_index,
  output logic [NUM_LANE*DOFF_W-1:0]   out_data_offset,
  output logic                         bad_lane
);

  localparam int ENTRY_W = VS_W + OFFSET_W + IDX_W + DOFF_W;

  logic [LANE_W-1:0]   w_lane    [NUM_IN];
  logic [NUM_IN-1:0]   w_req     [NUM_LANE];
  logic                w_gnt_vld [NUM_LANE];
  logic [IDX_W-1:0]    w_gnt_idx [NUM_LANE];
  logic [ENTRY_W-1:0]  w_new     [NUM_LANE];
  logic [NUM_LANE-1:0] w_push;
  logic [NUM_LANE-1:0] w_pop;
  logic                w_bad;

  logic [1:0]          r_cnt  [NUM_LANE];
  logic [IDX_W-1:0]    r_ptr  [NUM_LANE];
  logic [ENTRY_W-1:0]  r_head [NUM_LANE];
  logic [ENTRY_W-1:0]  r_tail [NUM_LANE];
  logic                r_bad;

  // First requester at or above ptr, wrapping modulo NUM_IN; returns {found, index}.
  function automatic logic [IDX_W:0] rr_pick(input logic [NUM_IN-1:0] req,
                                             input logic [IDX_W-1:0]  ptr);
    logic [IDX_W:0] res;
    res = '0;
    for (int k = NUM_IN - 1; k >= 0; k--) begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (req[i] && (((int'(ptr) + k) % NUM_IN) == i)) res = {1'b1, IDX_W'(i)};
      end
    end
    return res;
  endfunction

  for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_lane_sel
    assign w_lane[gi] = in_read_lane[gi*LANE_W +: LANE_W];
  end

  always_comb begin
    w_bad    = 1'b0;
    in_ready = '0;
    w_push   = '0;
    w_pop    = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (in_valid[i] && (32'(w_lane[i]) >= 32'(NUM_LANE))) w_bad = 1'b1;
    end
    for (int l = 0; l < NUM_LANE; l++) begin
      w_req[l] = '0;
      w_new[l] = '0;
      for (int i = 0; i < NUM_IN; i++) begin
        w_req[l][i] = in_valid[i] && (32'(w_lane[i]) == 32'(l));
      end
      {w_gnt_vld[l], w_gnt_idx[l]} = rr_pick(w_req[l], r_ptr[l]);
      // Full check uses the registered count only, so a pop frees a slot one cycle later.
      w_push[l] = reset && w_gnt_vld[l] && (r_cnt[l] != 2'd2);
      w_pop[l]  = (r_cnt[l] != 2'd0) && out_ready[l];
      for (int i = 0; i < NUM_IN; i++) begin
        if (w_gnt_idx[l] == IDX_W'(i)) begin
          w_new[l] = {in_vs[i*VS_W +: VS_W], in_offset[i*OFFSET_W +: OFFSET_W],
                      IDX_W'(i), in_data_offset[i*DOFF_W +: DOFF_W]};
          if (w_push[l]) in_ready[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int l = 0; l < NUM_LANE; l++) begin
        r_cnt[l] <= '0;
        r_ptr[l] <= '0;
      end
      r_bad <= 1'b0;
    end else begin
      for (int l = 0; l < NUM_LANE; l++) begin
        case ({w_push[l], w_pop[l]})
          2'b10:   r_cnt[l] <= r_cnt[l] + 2'd1;
          2'b01:   r_cnt[l] <= r_cnt[l] - 2'd1;
          default: r_cnt[l] <= r_cnt[l];
        endcase
        if (w_push[l]) begin
          r_ptr[l] <= (32'(w_gnt_idx[l]) == 32'(NUM_IN - 1)) ? '0 : w_gnt_idx[l] + 1'b1;
        end
      end
      if (w_bad) r_bad <= 1'b1;
    end
  end

  // FIFO storage is not reset: contents are only observed while count is nonzero.
  always_ff @(posedge clock) begin
    for (int l = 0; l < NUM_LANE; l++) begin
      if (w_push[l] && ((r_cnt[l] == 2'd0) || ((r_cnt[l] == 2'd1) && w_pop[l]))) begin
        r_head[l] <= w_new[l];
      end else if (w_pop[l] && (r_cnt[l] == 2'd2)) begin
        r_head[l] <= r_tail[l];
      end
      if (w_push[l] && (r_cnt[l] == 2'd1) && !w_pop[l]) r_tail[l] <= w_new[l];
    end
  end

  for (genvar gl = 0; gl < NUM_LANE; gl++) begin : g_out
    assign out_valid[gl]                         = (r_cnt[gl] != 2'd0);
    assign out_vs[gl*VS_W +: VS_W]               = r_head[gl][ENTRY_W-1 -: VS_W];
    assign out_offset[gl*OFFSET_W +: OFFSET_W]   = r_head[gl][IDX_W+DOFF_W +: OFFSET_W];
    assign out_write_index[gl*IDX_W +: IDX_W]    = r_head[gl][DOFF_W +: IDX_W];
    assign out_data_offset[gl*DOFF_W +: DOFF_W]  = r_head[gl][DOFF_W-1:0];
  end

  assign bad_lane = r_bad;

endmodule
